// File: rtl/pc_pkg.sv
// pc_pkg: shared state and next-PC select types for the fetch PC unit
package pc_pkg;
  typedef enum logic {RUN, HALTED} state_t;
  typedef enum logic [2:0] {SEL_HOLD, SEL_RAS, SEL_JUMP, SEL_BRANCH, SEL_SEQ} sel_t;
endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: control inputs and PC/RAS status outputs of the fetch PC unit
interface pc_unit_if #(
  parameter int WIDTH = 16,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  logic stall;
  logic halt;
  logic jump;
  logic call;
  logic ret;
  logic [WIDTH-1:0] jump_target;
  logic branch;
  logic branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] next_pc;
  logic halted;
  logic ras_empty;
  logic [CW-1:0] ras_count;
  modport master (
    output stall, halt, jump, call, ret, jump_target, branch, branch_taken, branch_target,
    input pc, pc_plus, next_pc, halted, ras_empty, ras_count
  );
  modport slave (
    input stall, halt, jump, call, ret, jump_target, branch, branch_taken, branch_target,
    output pc, pc_plus, next_pc, halted, ras_empty, ras_count
  );
endinterface

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry
module pc_ras
  import pc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int RAS_DEPTH = 4,
  localparam int PW = $clog2(RAS_DEPTH),
  localparam int CW = $clog2(RAS_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);
  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0] ptr_q, ptr_d, top_idx;
  logic [CW-1:0] count_q, count_d;
  logic do_pop;
  // ptr_q is the next write slot; the top sits one slot behind it, wrapping modulo depth
  always_comb begin
    do_pop = pop_i && count_q != '0;
    top_idx = ptr_q == '0 ? PW'(RAS_DEPTH - 1) : ptr_q - 1'b1;
    ptr_d = push_i ? (ptr_q == PW'(RAS_DEPTH - 1) ? '0 : ptr_q + 1'b1) : do_pop ? top_idx : ptr_q;
    count_d = push_i ? (count_q == CW'(RAS_DEPTH) ? count_q : count_q + 1'b1) : do_pop ? count_q - 1'b1 : count_q;
  end
  // pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      count_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      count_q <= count_d;
    end
  end
  // entry storage needs no reset; stale entries are never read while count is zero
  always_ff @(posedge clk) begin
    if (push_i) mem_q[ptr_q] <= push_data_i;
  end
  assign top_o = mem_q[top_idx];
  assign count_o = count_q;
  assign empty_o = count_q == '0;
endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage PC register with prioritised next-PC select, RAS and halt state
module pc_unit
  import pc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int INC = 2,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int RAS_DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  pc_unit_if.slave bus
);
  state_t state_q, state_d;
  sel_t sel;
  logic [WIDTH-1:0] pc_q, pc_d, pc_plus, ras_top;
  logic ras_empty, accept, push, pop;
  // priority select: halted/halt/stall hold; a ret on an empty RAS falls back to jump_target
  always_comb begin
    sel = (state_q == HALTED || bus.halt || bus.stall) ? SEL_HOLD :
          bus.ret ? (ras_empty ? SEL_JUMP : SEL_RAS) :
          bus.jump ? SEL_JUMP :
          (bus.branch && bus.branch_taken) ? SEL_BRANCH : SEL_SEQ;
    pc_d = sel == SEL_RAS ? ras_top :
           sel == SEL_JUMP ? bus.jump_target :
           sel == SEL_BRANCH ? bus.branch_target :
           sel == SEL_SEQ ? pc_plus : pc_q;
    state_d = (state_q == RUN && bus.halt && !bus.stall) ? HALTED : state_q;
    accept = state_q == RUN && !bus.halt && !bus.stall;
    push = accept && bus.call && bus.jump && !bus.ret;
    pop = accept && bus.ret;
  end
  // PC register and run/halted state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      state_q <= RUN;
    end else begin
      pc_q <= pc_d;
      state_q <= state_d;
    end
  end
  assign pc_plus = pc_q + WIDTH'(INC);
  pc_ras #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk),
    .rst_n(rst_n),
    .push_i(push),
    .pop_i(pop),
    .push_data_i(pc_plus),
    .top_o(ras_top),
    .count_o(bus.ras_count),
    .empty_o(ras_empty)
  );
  assign bus.pc = pc_q;
  assign bus.pc_plus = pc_plus;
  assign bus.next_pc = pc_d;
  assign bus.halted = state_q == HALTED;
  assign bus.ras_empty = ras_empty;
endmodule
